// File: rtl/spfp_nr_divider.sv
// spfp_nr_divider
//   Sequential IEEE-754 single-precision divider. The divisor mantissa is
//   rescaled into [0.5,1), a linear reciprocal seed is formed, and ITERS
//   Newton-Raphson steps X <= X*(2 - D'*X) run one per clock. The dividend
//   magnitude is then multiplied by the reciprocal and the exponent is
//   corrected for the divisor scaling. Denormal operands and results are
//   flushed to signed zero.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      operands A/D valid
//   in_ready      idle, operands accepted on in_valid & in_ready
//   A, D          dividend, divisor (IEEE-754 single)
//   out_valid     Q and flags valid; held until out_ready
//   out_ready     consumer accepts result
//   Q             A/D (IEEE-754 single)
//   div_by_zero   finite nonzero A divided by zero
//   invalid       0/0, inf/inf or a NaN operand

module spfp_nr_divider #(
  parameter int unsigned ITERS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Q,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [31:0] TWO    = 32'h4000_0000;
  localparam logic [31:0] SEED_K = 32'h4034_B4B5;  // 48/17
  localparam logic [31:0] SEED_M = 32'h3FF0_F0F1;  // 32/17
  localparam logic [31:0] NEG    = 32'h8000_0000;
  localparam logic [2:0]  LAST   = 3'(ITERS - 1);

  typedef enum logic [2:0] {IDLE, SEED, ITER, MUL, SCALE, DONE} state_t;

  // Product of two nonzero normals, round-to-nearest-even.
  // Returns {biased exponent as 10-bit two's complement, fraction}; the
  // exponent is left unsaturated so callers can rescale it afterwards.
  function automatic logic [32:0] mul_core(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, p;
    logic [9:0]  e;
    logic [23:0] m;
    logic [24:0] mr;
    logic        g, st;
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    // rounding carried out to 2.0: fraction bits are already zero
    if (mr[24]) e = e + 10'd1;
    return {e, mr[22:0]};
  endfunction

  // Saturate a signed biased exponent: underflow flushes to zero, overflow to inf.
  function automatic logic [31:0] pack(input logic s, input logic [9:0] e, input logic [22:0] f);
    if ($signed(e) <= 10'sd0)   return {s, 31'd0};
    if ($signed(e) >= 10'sd255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], f};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] c;
    c = mul_core(a, b);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    return pack(a[31] ^ b[31], c[32:23], c[22:0]);
  endfunction

  // Signed add of two finite operands, round-to-nearest-even, FTZ.
  // Working mantissa: [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  d;
    logic [26:0] mx, my, lost;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] mr;
    logic        sub;
    if (b[30:23] == 8'd0) return (a[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : a;
    if (a[30:23] == 8'd0) return b;
    // larger magnitude first so the aligned difference never goes negative
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sub = x[31] ^ y[31];
    d   = x[30:23] - y[30:23];
    mx  = {1'b1, x[22:0], 3'b000};
    my  = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) begin
      my = 27'd1;  // smaller operand survives only as sticky
    end else begin
      lost = my & ((27'd1 << d) - 27'd1);
      my   = (my >> d) | {26'd0, |lost};
    end
    s = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    if (s == 28'd0) return 32'd0;
    e = {2'b00, x[30:23]};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int unsigned i = 0; i < 26; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    mr = {1'b0, s[26:3]} + {24'd0, s[2] & ((|s[1:0]) | s[3])};
    if (mr[24]) e = e + 10'd1;
    return pack(x[31], e, mr[22:0]);
  endfunction

  state_t      state;
  logic [31:0] a_reg, d_reg, x;
  logic [2:0]  cnt;
  logic [9:0]  p_exp;
  logic [22:0] p_frac;

  // Operand classification on the input bus; denormals count as zero.
  logic a_zero, a_inf, a_nan, d_zero, d_inf, d_nan, q_sign;
  always_comb begin
    a_zero = (A[30:23] == 8'd0);
    a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    d_zero = (D[30:23] == 8'd0);
    d_inf  = (D[30:23] == 8'hFF) && (D[22:0] == 23'd0);
    d_nan  = (D[30:23] == 8'hFF) && (D[22:0] != 23'd0);
    q_sign = A[31] ^ D[31];
  end

  // Datapath for the registered operands.
  logic [31:0] dp, seed, x_next;
  logic [32:0] p_core;
  logic [9:0]  e_q;
  always_comb begin
    dp     = {1'b0, 8'd126, d_reg[22:0]};
    seed   = fp_add(SEED_K, fp_mul(SEED_M, dp) ^ NEG);
    x_next = fp_mul(x, fp_add(TWO, fp_mul(dp, x) ^ NEG));
    p_core = mul_core({1'b0, a_reg[30:0]}, x);
    // 1/D = X * 2^-(Dexp-126)
    e_q    = p_exp - {2'b00, d_reg[30:23]} + 10'd126;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      Q           <= '0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
      a_reg       <= '0;
      d_reg       <= '0;
      x           <= '0;
      cnt         <= '0;
      p_exp       <= '0;
      p_frac      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready    <= 1'b0;
            a_reg       <= A;
            d_reg       <= D;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            state       <= DONE;
            if (a_nan || d_nan || (a_zero && d_zero) || (a_inf && d_inf)) begin
              Q       <= QNAN;
              invalid <= 1'b1;
            end else if (d_zero && !a_inf) begin
              Q           <= {q_sign, 8'hFF, 23'd0};
              div_by_zero <= 1'b1;
            end else if (a_inf) begin
              Q <= {q_sign, 8'hFF, 23'd0};
            end else if (d_inf || a_zero) begin
              Q <= {q_sign, 31'd0};
            end else begin
              state <= SEED;
            end
          end
        end
        SEED: begin
          x     <= seed;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          x   <= x_next;
          cnt <= cnt + 3'd1;
          if (cnt == LAST) state <= MUL;
        end
        MUL: begin
          p_exp  <= p_core[32:23];
          p_frac <= p_core[22:0];
          state  <= SCALE;
        end
        SCALE: begin
          Q     <= pack(a_reg[31] ^ d_reg[31], e_q, p_frac);
          state <= DONE;
        end
        DONE: begin
          // out_valid rises one edge after entering DONE
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
